// File: rtl/rtr_inp_logic_if.sv
// rtl/rtr_inp_logic_if.sv - link, SA request/grant and status signals of one router input
interface rtr_inp_logic_if #(
  parameter int OUT_PORTS  = 4,
  parameter int FLIT_WIDTH = 16
);
  logic [FLIT_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  credit_out;
  logic [OUT_PORTS-1:0]  outp_avail;
  logic [OUT_PORTS-1:0]  outp_ready;
  logic [OUT_PORTS-1:0]  sa_reqs;
  logic [OUT_PORTS-1:0]  sa_grants;
  logic [FLIT_WIDTH-1:0] data_out;
  logic [1:0]            err;

  // Router input side
  modport slave (
    input  data_in, valid_in, outp_avail, outp_ready, sa_grants,
    output credit_out, sa_reqs, data_out, err
  );

  // Upstream link / output logic / arbiter side
  modport master (
    output data_in, valid_in, outp_avail, outp_ready, sa_grants,
    input  credit_out, sa_reqs, data_out, err
  );
endinterface

// File: rtl/rtr_inp_logic.sv
// rtl/rtr_inp_logic.sv - per-input flit buffer, credit return and switch-allocation requests
// Flit type lives in data[1:0]: 00 body, 01 head, 10 tail, 11 single.
// The route field sits directly above the type field.
module rtr_inp_logic #(
  parameter int OUT_PORTS  = 4,
  parameter int FLIT_WIDTH = 16,
  parameter int BUF_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst,
  rtr_inp_logic_if.slave  bus
);
  localparam int FLIT_FIELD_WIDTH = 2;
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(OUT_PORTS);

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [FLIT_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [PW-1:0]         r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]         r_count;
  state_t                r_state;
  logic [RW-1:0]         r_route;
  logic [1:0]            r_err;

  state_t                w_state_nxt;
  logic [FLIT_WIDTH-1:0] w_front;
  logic [1:0]            w_type;
  logic [RW-1:0]         w_rte;
  logic [RW-1:0]         w_sel;
  logic [OUT_PORTS-1:0]  w_sel_oh;
  logic                  w_empty, w_full;
  logic                  w_req, w_deq, w_wr, w_ovf, w_bad_head, w_route_ld;

  assign w_front  = r_mem[r_rd_ptr];
  assign w_type   = w_front[FLIT_FIELD_WIDTH-1:0];
  assign w_rte    = w_front[FLIT_FIELD_WIDTH +: RW];
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(BUF_DEPTH));
  // In IDLE the head's own route is requested; in ACTIVE the latched connection.
  assign w_sel    = (r_state == IDLE) ? w_rte : r_route;
  assign w_sel_oh = {{(OUT_PORTS-1){1'b0}}, 1'b1} << w_sel;

  // A full FIFO still accepts a write when a flit leaves in the same cycle.
  assign w_wr  = bus.valid_in & (~w_full | w_deq);
  assign w_ovf = bus.valid_in & w_full & ~w_deq;

  assign bus.data_out   = w_front;
  assign bus.sa_reqs    = w_req ? w_sel_oh : '0;
  assign bus.credit_out = w_deq;
  assign bus.err        = r_err;

  // Request, dequeue and next-state decision for the flit at the FIFO front
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_deq       = 1'b0;
    w_bad_head  = 1'b0;
    w_route_ld  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          if (w_type == FT_HEAD || w_type == FT_SINGLE) begin
            w_req = bus.outp_avail[w_rte] & bus.outp_ready[w_rte];
            if (w_req && bus.sa_grants[w_rte]) begin
              w_deq = 1'b1;
              if (w_type == FT_HEAD) begin
                w_route_ld  = 1'b1;
                w_state_nxt = ACTIVE;
              end
            end
          end else begin
            // Body/tail with no open connection: discard it but still return its credit.
            w_deq      = 1'b1;
            w_bad_head = 1'b1;
          end
        end
      end
      ACTIVE: begin
        // The output was claimed by our head; only downstream credit matters now.
        w_req = ~w_empty & bus.outp_ready[r_route];
        if (w_req && bus.sa_grants[r_route]) begin
          w_deq = 1'b1;
          if (w_type == FT_TAIL) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FIFO storage, written without reset since contents are qualified by r_count
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.data_in;
  end

  // Pointers, occupancy, connection state and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_state  <= IDLE;
      r_route  <= '0;
      r_err    <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_deq);
      r_state <= w_state_nxt;
      if (w_route_ld) r_route <= w_rte;
      r_err <= r_err | {w_bad_head, w_ovf};
    end
  end
endmodule

// File: tb/tb_rtr_inp_logic.sv
// tb/tb_rtr_inp_logic.sv - bench for rtr_inp_logic against a queue-based reference model
module tb_rtr_inp_logic;
  localparam int NP = 4;
  localparam int FW = 16;
  localparam int BD = 4;

  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;
  localparam int G_ECHO = 0, G_NONE = 1, G_RAND = 2;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  rtr_inp_logic_if #(.OUT_PORTS(NP), .FLIT_WIDTH(FW)) bus ();

  rtr_inp_logic #(.OUT_PORTS(NP), .FLIT_WIDTH(FW), .BUF_DEPTH(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [FW-1:0] m_q[$];
  bit            m_in_pkt;
  logic [1:0]    m_route;
  logic [1:0]    m_err;
  logic [NP-1:0] e_req;
  bit            e_deq;
  bit            e_bad;

  logic [NP-1:0] last_req;
  logic          last_cred;
  logic [FW-1:0] last_data;
  logic [1:0]    last_err;
  int            cred_cnt;

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [1:0] r);
    logic [11:0] pl;
    pl = 12'($urandom);
    return {pl, r, t};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_in_pkt = 0;
    m_route  = '0;
    m_err    = '0;
  endtask

  // What the input should do this cycle, from the packet rules alone
  task automatic model_eval(input logic [NP-1:0] av, input logic [NP-1:0] rd, input logic [NP-1:0] g);
    logic [1:0] t, r;
    e_req = '0;
    e_deq = 0;
    e_bad = 0;
    if (m_q.size() > 0) begin
      t = m_q[0][1:0];
      r = m_q[0][3:2];
      if (!m_in_pkt) begin
        if (t == T_HEAD || t == T_SINGLE) begin
          if (av[r] && rd[r]) e_req = NP'(1) << r;
          e_deq = (e_req != 0) && g[r];
        end else begin
          e_deq = 1;
          e_bad = 1;
        end
      end else begin
        if (rd[m_route]) e_req = NP'(1) << m_route;
        e_deq = (e_req != 0) && g[m_route];
      end
    end
  endtask

  task automatic model_commit(input logic v, input logic [FW-1:0] d);
    logic [1:0] t;
    if (e_deq) begin
      t = m_q[0][1:0];
      if (!m_in_pkt && t == T_HEAD) begin
        m_in_pkt = 1;
        m_route  = m_q[0][3:2];
      end else if (m_in_pkt && t == T_TAIL) begin
        m_in_pkt = 0;
      end
      void'(m_q.pop_front());
    end
    if (e_bad) m_err[1] = 1'b1;
    if (v) begin
      if (m_q.size() < BD) m_q.push_back(d);
      else m_err[0] = 1'b1;
    end
  endtask

  // One clock cycle: drive at posedge+1, compare at posedge+4, commit model at the edge
  task automatic step(input logic v, input logic [FW-1:0] d, input logic [NP-1:0] av,
                      input logic [NP-1:0] rd, input int gm);
    logic [NP-1:0] g;
    bus.valid_in   = v;
    bus.data_in    = d;
    bus.outp_avail = av;
    bus.outp_ready = rd;
    model_eval(av, rd, '0);
    g = (gm == G_ECHO) ? e_req : (gm == G_NONE) ? '0 : NP'($urandom);
    bus.sa_grants = g;
    model_eval(av, rd, g);
    #3;
    last_req  = bus.sa_reqs;
    last_cred = bus.credit_out;
    last_data = bus.data_out;
    last_err  = bus.err;
    if (last_cred === 1'b1) cred_cnt++;
    check("sa_reqs", 32'(last_req), 32'(e_req));
    check("credit_out", 32'(last_cred), 32'(e_deq));
    check("err", 32'(last_err), 32'(m_err));
    if (m_q.size() > 0) check("data_out", 32'(last_data), 32'(m_q[0]));
    @(posedge clk);
    model_commit(v, d);
    #1;
  endtask

  logic [FW-1:0] f;

  initial begin
    rst = 1'b0;
    bus.valid_in = 0; bus.data_in = '0; bus.outp_avail = '0;
    bus.outp_ready = '0; bus.sa_grants = '0;
    model_reset();
    cred_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    step(0, '0, 4'hF, 4'hF, G_ECHO);
    check("rst_req", 32'(last_req), 32'h0);
    check("rst_err", 32'(last_err), 32'h0);

    // Single flit, route 2
    f = mk(T_SINGLE, 2'd2);
    step(1, f, 4'hF, 4'hF, G_ECHO);
    step(0, '0, 4'hF, 4'hF, G_ECHO);
    check("t1_req", 32'(last_req), 32'h4);
    check("t1_cred", 32'(last_cred), 32'h1);
    check("t1_data", 32'(last_data), 32'(f));
    step(0, '0, 4'hF, 4'hF, G_ECHO);
    check("t1_idle", 32'(last_req), 32'h0);

    // Head/body/tail on route 1, grant withheld, then downstream credit gap
    step(1, mk(T_HEAD, 2'd1), 4'hF, 4'hF, G_NONE);
    step(1, mk(T_BODY, 2'd0), 4'hF, 4'hF, G_NONE);
    step(1, mk(T_TAIL, 2'd3), 4'hF, 4'hF, G_NONE);
    check("t2_hold", 32'(last_req), 32'h2);
    cred_cnt = 0;
    step(0, '0, 4'hF, 4'hF, G_ECHO);
    step(0, '0, 4'hF, 4'hD, G_ECHO);
    check("t2_notready", 32'(last_req), 32'h0);
    step(0, '0, 4'hD, 4'hF, G_ECHO);
    check("t2_active_noavail", 32'(last_req), 32'h2);
    step(0, '0, 4'hF, 4'hF, G_ECHO);
    step(0, '0, 4'hF, 4'hF, G_ECHO);
    check("t2_credits", 32'(cred_cnt), 32'd3);

    // Head blocked by outp_avail, then overflow with five writes
    step(1, mk(T_HEAD, 2'd1), 4'hD, 4'hF, G_ECHO);
    step(1, mk(T_BODY, 2'd0), 4'hD, 4'hF, G_ECHO);
    check("t3_noavail", 32'(last_req), 32'h0);
    step(1, mk(T_BODY, 2'd0), 4'hF, 4'hF, G_NONE);
    step(1, mk(T_TAIL, 2'd0), 4'hF, 4'hF, G_NONE);
    step(1, mk(T_SINGLE, 2'd0), 4'hF, 4'hF, G_NONE);
    step(0, '0, 4'hF, 4'hF, G_NONE);
    check("t4_ovf", 32'(last_err), 32'h1);
    step(1, mk(T_SINGLE, 2'd3), 4'hF, 4'hF, G_ECHO);
    check("t4_full_wr_rd", 32'(last_cred), 32'h1);
    cred_cnt = 0;
    repeat (6) step(0, '0, 4'hF, 4'hF, G_ECHO);
    check("t4_drain", 32'(cred_cnt), 32'd4);
    check("t4_err_sticky", 32'(last_err), 32'h1);

    // Tail with no open packet
    step(1, mk(T_TAIL, 2'd2), 4'hF, 4'hF, G_ECHO);
    step(0, '0, 4'hF, 4'hF, G_ECHO);
    check("t5_cred", 32'(last_cred), 32'h1);
    check("t5_req", 32'(last_req), 32'h0);
    step(0, '0, 4'hF, 4'hF, G_ECHO);
    check("t5_err", 32'(last_err), 32'h3);

    // Asynchronous reset while ACTIVE with two flits buffered
    step(1, mk(T_HEAD, 2'd3), 4'hF, 4'hF, G_NONE);
    step(1, mk(T_BODY, 2'd0), 4'hF, 4'hF, G_NONE);
    step(1, mk(T_BODY, 2'd0), 4'hF, 4'hF, G_NONE);
    step(0, '0, 4'hF, 4'hF, G_ECHO);
    bus.outp_ready = 4'hF;
    bus.sa_grants  = 4'h8;
    #1;
    check("t6_pre_req", 32'(bus.sa_reqs), 32'h8);
    rst = 1'b0;
    #1;
    check("t6_rst_req", 32'(bus.sa_reqs), 32'h0);
    check("t6_rst_cred", 32'(bus.credit_out), 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    step(0, '0, 4'hF, 4'hF, G_ECHO);
    check("t6_err", 32'(last_err), 32'h0);
    step(1, mk(T_HEAD, 2'd0), 4'hF, 4'hF, G_NONE);
    step(0, '0, 4'hF, 4'hF, G_NONE);
    check("t6_idle_req", 32'(last_req), 32'h1);
    step(1, mk(T_TAIL, 2'd0), 4'hF, 4'hF, G_ECHO);
    step(0, '0, 4'hF, 4'hF, G_ECHO);

    // Randomized traffic with random or echoed grants
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) != 0),
           mk(($urandom_range(0, 3) == 0) ? 2'($urandom) : (($urandom_range(0, 1) == 0) ? T_BODY : T_SINGLE), 2'($urandom)),
           NP'($urandom) | 4'h5, NP'($urandom) | 4'h3,
           ($urandom_range(0, 1) == 0) ? G_ECHO : G_RAND);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
